oam_line_scanner: RTL and testbench

//  Parametrised per-scanline sprite selector for the PPU. On a start pulse it walks

---
 rtl/ppu_pkg.sv | 14 +
 rtl/sprite_buffer_ram.sv | 22 ++
 rtl/oam_line_scanner.sv | 117 +++++++++++
 tb/tb_oam_line_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared sprite-scan types and constants for the PPU object pipeline
package ppu_pkg;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] flags;
    logic [3:0] row;
  } sprite_entry_t;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ_Y, S_REQ_X, S_REQ_T, S_REQ_F, S_NEXT, S_DONE
  } scan_state_t;
  localparam int OAM_ENTRY_BYTES = 4;
  localparam int SPRITE_Y_OFFSET = 16;
endpackage

// File: rtl/sprite_buffer_ram.sv
// sprite_buffer_ram: per-line sprite buffer, one write port and one registered read port
module sprite_buffer_ram
  import ppu_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sprite_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output sprite_entry_t rdata
);
  sprite_entry_t mem [DEPTH];
  always_ff @(posedge clk_in)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/oam_line_scanner.sv
// oam_line_scanner: walks OAM for one scanline and collects the visible sprites in order
module oam_line_scanner
  import ppu_pkg::*;
#(
  parameter int          NUM_SPRITES = 40,
  parameter int          BUFFER_MAX  = 10,
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter bit          SKIP_X_ZERO = 1'b1,
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1,
  localparam int CW = $clog2(BUFFER_MAX + 1),
  localparam int RW = BUFFER_MAX > 1 ? $clog2(BUFFER_MAX) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [7:0]    LY_in,
  input  logic          tall_in,
  output logic [15:0]   addr_out,
  output logic          addr_valid_out,
  input  logic [7:0]    data_in,
  input  logic          data_valid_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [CW-1:0] count_out,
  output logic          overflow_out,
  input  logic [RW-1:0] rd_idx_in,
  output sprite_entry_t rd_entry_out
);
  scan_state_t   state;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic          ovf, tall, wr_pend;
  logic [8:0]    ly16;
  logic [7:0]    y, x, tile, flags;
  logic [1:0]    off;
  logic [8:0]    y9;
  logic          req, hit, full, last, store;
  sprite_entry_t wdata;
  always_comb begin
    off   = state == S_REQ_X ? 2'd1 : state == S_REQ_T ? 2'd2 : state == S_REQ_F ? 2'd3 : 2'd0;
    req   = state inside {S_REQ_Y, S_REQ_X, S_REQ_T, S_REQ_F};
    y9    = {1'b0, data_in};
    hit   = (y9 <= ly16) && (ly16 < y9 + (tall ? 9'd16 : 9'd8));
    full  = count == CW'(BUFFER_MAX);
    last  = idx == IW'(NUM_SPRITES - 1);
    store = state == S_NEXT && wr_pend && !(SKIP_X_ZERO && x == 8'd0);
    wdata = '{x: x, tile: tile, flags: flags, row: 4'(ly16 - {1'b0, y})};
  end
  assign addr_out       = req ? OAM_BASE + 16'({idx, off}) : 16'd0;
  assign addr_valid_out = req;
  assign busy_out       = state != S_IDLE && state != S_DONE;
  assign done_out       = state == S_DONE;
  assign count_out      = count;
  assign overflow_out   = ovf;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      idx     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      tall    <= 1'b0;
      wr_pend <= 1'b0;
      ly16    <= '0;
      y       <= '0;
      x       <= '0;
      tile    <= '0;
      flags   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_in) begin
          ly16  <= {1'b0, LY_in} + 9'(SPRITE_Y_OFFSET);
          tall  <= tall_in;
          idx   <= '0;
          count <= '0;
          ovf   <= 1'b0;
          state <= S_REQ_Y;
        end
        S_REQ_Y: if (data_valid_in) begin
          y     <= data_in;
          ovf   <= ovf | (hit && full);
          state <= hit && !full ? S_REQ_X : S_NEXT;
        end
        S_REQ_X: if (data_valid_in) begin
          x     <= data_in;
          state <= S_REQ_T;
        end
        // 8x16 sprites address the tile pair through the even index
        S_REQ_T: if (data_valid_in) begin
          tile  <= tall ? {data_in[7:1], 1'b0} : data_in;
          state <= S_REQ_F;
        end
        S_REQ_F: if (data_valid_in) begin
          flags   <= data_in;
          wr_pend <= 1'b1;
          state   <= S_NEXT;
        end
        S_NEXT: begin
          wr_pend <= 1'b0;
          count   <= store ? count + CW'(1) : count;
          idx     <= last ? idx : idx + IW'(1);
          state   <= last ? S_DONE : S_REQ_Y;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  sprite_buffer_ram #(.DEPTH(BUFFER_MAX), .AW(RW)) u_buf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we     (store),
    .waddr  (RW'(count)),
    .wdata  (wdata),
    .raddr  (rd_idx_in),
    .rdata  (rd_entry_out)
  );
endmodule

// File: tb/tb_oam_line_scanner.sv
// tb_oam_line_scanner: directed table plus randomized scans of two scanner variants against a line-walk model
module tb_oam_line_scanner;
  import ppu_pkg::*;
  localparam int N = 40;
  localparam int B = 10;
  localparam logic [15:0] BASE = 16'hFE00;

  logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, tall_in = 1'b0;
  logic [7:0] LY_in = '0;
  logic [3:0] rd_idx_in = '0;
  logic [7:0] data_in [2];
  logic dv [2];
  logic [15:0] addr [2];
  logic av [2], busy [2], done [2], ovf [2];
  logic [3:0] cnt [2];
  sprite_entry_t ent [2];

  logic [7:0] oam [N*4];
  int max_delay = 0;
  int reads [2];
  int addr_bad = 0;
  int n_cmp = 0, n_bad = 0;
  int m_cnt [2], m_rd [2];
  bit m_ovf [2];
  sprite_entry_t m_ent [2][B];

  typedef struct {
    int scen; logic [7:0] ly; bit tall;
    int c0; bit o0; int c1; bit o1; logic [27:0] e0;
  } vec_t;
  vec_t tbl [6];

  always #5 clk_in = ~clk_in;

  oam_line_scanner #(.NUM_SPRITES(N), .BUFFER_MAX(B), .OAM_BASE(BASE), .SKIP_X_ZERO(1'b1)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .LY_in(LY_in), .tall_in(tall_in),
    .addr_out(addr[0]), .addr_valid_out(av[0]), .data_in(data_in[0]), .data_valid_in(dv[0]),
    .busy_out(busy[0]), .done_out(done[0]), .count_out(cnt[0]), .overflow_out(ovf[0]),
    .rd_idx_in(rd_idx_in), .rd_entry_out(ent[0]));
  oam_line_scanner #(.NUM_SPRITES(N), .BUFFER_MAX(B), .OAM_BASE(BASE), .SKIP_X_ZERO(1'b0)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .LY_in(LY_in), .tall_in(tall_in),
    .addr_out(addr[1]), .addr_valid_out(av[1]), .data_in(data_in[1]), .data_valid_in(dv[1]),
    .busy_out(busy[1]), .done_out(done[1]), .count_out(cnt[1]), .overflow_out(ovf[1]),
    .rd_idx_in(rd_idx_in), .rd_entry_out(ent[1]));

  // OAM responders: each scanner owns its own bus with random response latency
  initial begin
    int w [2];
    logic [15:0] la [2];
    bit pend [2];
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; data_in[i] = '0; w[i] = -1; pend[i] = 0; reads[i] = 0; la[i] = '0;
    end
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < 2; i++) begin
        if (rst_in || dv[i]) begin
          dv[i] = 1'b0; w[i] = -1; pend[i] = 0;
        end else if (av[i]) begin
          if (pend[i] && addr[i] != la[i]) addr_bad++;
          if (addr[i] < BASE || addr[i] >= BASE + 16'(N*4)) addr_bad++;
          pend[i] = 1; la[i] = addr[i];
          if (w[i] < 0) w[i] = int'($urandom_range(max_delay, 0));
          if (w[i] == 0) begin
            dv[i] = 1'b1;
            data_in[i] = oam[int'(addr[i] - BASE) % (N*4)];
            reads[i]++;
          end else w[i]--;
        end else pend[i] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: a direct walk of the line-selection rules over the OAM image
  task automatic model(input int i, input logic [7:0] ly, input bit t);
    int ly16, h, y;
    ly16 = int'(ly) + 16; h = t ? 16 : 8;
    m_cnt[i] = 0; m_ovf[i] = 0; m_rd[i] = 0;
    for (int k = 0; k < N; k++) begin
      y = int'(oam[4*k]);
      m_rd[i]++;
      if (y <= ly16 && ly16 < y + h) begin
        if (m_cnt[i] == B) m_ovf[i] = 1;
        else begin
          m_rd[i] += 3;
          if (!(i == 0 && oam[4*k+1] == 8'd0)) begin
            m_ent[i][m_cnt[i]] = {oam[4*k+1], t ? (oam[4*k+2] & 8'hFE) : oam[4*k+2],
                                  oam[4*k+3], 4'(ly16 - y)};
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic scan(input logic [7:0] ly, input bit t, input string tag);
    int r0 [2], b0;
    bit seen [2];
    b0 = addr_bad;
    for (int i = 0; i < 2; i++) begin r0[i] = reads[i]; seen[i] = 0; end
    @(negedge clk_in);
    LY_in = ly; tall_in = t; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0; LY_in = 8'($urandom); tall_in = ~t;
    chk({tag, " busy"}, 32'(busy[0] & busy[1]), 32'd1);
    for (int c = 0; c < 5000 && !(seen[0] && seen[1]); c++) begin
      @(negedge clk_in);
      if (c == 5) begin LY_in = ly + 8'd50; start_in = 1'b1; end
      if (c == 6) start_in = 1'b0;
      for (int i = 0; i < 2; i++) if (done[i]) seen[i] = 1;
    end
    start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model(i, ly, t);
      chk($sformatf("%s u%0d done", tag, i), 32'(seen[i]), 32'd1);
      chk($sformatf("%s u%0d count", tag, i), 32'(cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("%s u%0d overflow", tag, i), 32'(ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("%s u%0d reads", tag, i), 32'(reads[i] - r0[i]), 32'(m_rd[i]));
      chk($sformatf("%s u%0d busy", tag, i), 32'(busy[i]), 32'd0);
    end
    chk({tag, " addr"}, 32'(addr_bad - b0), 32'd0);
    for (int k = 0; k < B; k++) begin
      rd_idx_in = 4'(k);
      @(negedge clk_in);
      for (int i = 0; i < 2; i++)
        if (k < m_cnt[i]) chk($sformatf("%s u%0d entry%0d", tag, i, k), 32'(ent[i]), 32'(m_ent[i][k]));
    end
  endtask

  task automatic fill(input int scen);
    for (int k = 0; k < N*4; k++) oam[k] = 8'd0;
    case (scen)
      0: begin oam[12] = 8'd16; oam[13] = 8'd20; oam[14] = 8'h33; oam[15] = 8'h80; end
      1: for (int k = 0; k < 12; k++) begin
           oam[4*k] = 8'd16; oam[4*k+1] = 8'd8; oam[4*k+2] = 8'(k); oam[4*k+3] = 8'(k);
         end
      2, 3: begin oam[0] = 8'd16; oam[1] = 8'd50; oam[2] = 8'h05; oam[3] = 8'h10; end
      4: begin oam[20] = 8'd16; oam[21] = 8'd0; oam[22] = 8'h07; oam[23] = 8'h01; end
      5: begin
           oam[0] = 8'd160; oam[1] = 8'hFF; oam[2] = 8'hFF; oam[3] = 8'hFF;
           oam[4] = 8'd153; oam[5] = 8'd9;  oam[6] = 8'h12; oam[7] = 8'h34;
           oam[8] = 8'd152; oam[9] = 8'd9;
         end
      default: ;
    endcase
  endtask

  initial begin
    int r0, spread;
    logic [7:0] ly;
    tbl[0] = '{0, 8'd0,   1'b0, 1,  1'b0, 1,  1'b0, {8'd20, 8'h33, 8'h80, 4'd0}};
    tbl[1] = '{1, 8'd0,   1'b0, 10, 1'b1, 10, 1'b1, {8'd8,  8'h00, 8'h00, 4'd0}};
    tbl[2] = '{2, 8'd15,  1'b1, 1,  1'b0, 1,  1'b0, {8'd50, 8'h04, 8'h10, 4'hF}};
    tbl[3] = '{3, 8'd15,  1'b0, 0,  1'b0, 0,  1'b0, 28'd0};
    tbl[4] = '{4, 8'd0,   1'b0, 0,  1'b0, 1,  1'b0, {8'd0,  8'h07, 8'h01, 4'd0}};
    tbl[5] = '{5, 8'd144, 1'b0, 2,  1'b0, 2,  1'b0, {8'hFF, 8'hFF, 8'hFF, 4'd0}};
    for (int k = 0; k < N*4; k++) oam[k] = 8'd0;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset u%0d busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset u%0d done", i), 32'(done[i]), 32'd0);
      chk($sformatf("reset u%0d addr_valid", i), 32'(av[i]), 32'd0);
      chk($sformatf("reset u%0d addr", i), 32'(addr[i]), 32'd0);
      chk($sformatf("reset u%0d count", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("reset u%0d overflow", i), 32'(ovf[i]), 32'd0);
      chk($sformatf("reset u%0d entry", i), 32'(ent[i]), 32'd0);
    end
    rst_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      max_delay = d * 5;
      foreach (tbl[v]) begin
        fill(tbl[v].scen);
        scan(tbl[v].ly, tbl[v].tall, $sformatf("vec%0d/d%0d", v, max_delay));
        chk($sformatf("vec%0d u0 count", v), 32'(cnt[0]), 32'(tbl[v].c0));
        chk($sformatf("vec%0d u0 overflow", v), 32'(ovf[0]), 32'(tbl[v].o0));
        chk($sformatf("vec%0d u1 count", v), 32'(cnt[1]), 32'(tbl[v].c1));
        chk($sformatf("vec%0d u1 overflow", v), 32'(ovf[1]), 32'(tbl[v].o1));
        rd_idx_in = 4'd0;
        @(negedge clk_in);
        if (tbl[v].c0 > 0) chk($sformatf("vec%0d u0 entry0", v), 32'(ent[0]), 32'(tbl[v].e0));
        if (tbl[v].c1 > 0) chk($sformatf("vec%0d u1 entry0", v), 32'(ent[1]), 32'(tbl[v].e0));
      end
    end
    // reset while scanning entry 17: sprite 3 is already stored
    fill(0);
    max_delay = 2;
    r0 = reads[0];
    @(negedge clk_in);
    LY_in = 8'd0; tall_in = 1'b0; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int c = 0; c < 2000 && reads[0] - r0 < 21; c++) @(negedge clk_in);
    chk("midreset reached idx17", 32'(reads[0] - r0), 32'd21);
    chk("midreset pre count", 32'(cnt[0]), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset u%0d busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("midreset u%0d addr_valid", i), 32'(av[i]), 32'd0);
      chk($sformatf("midreset u%0d count", i), 32'(cnt[i]), 32'd0);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    scan(8'd0, 1'b0, "restart");
    for (int r = 0; r < 20; r++) begin
      max_delay = int'($urandom_range(5, 0));
      ly = 8'($urandom_range(150, 0));
      spread = int'($urandom_range(80, 20));
      for (int k = 0; k < N; k++) begin
        oam[4*k]   = 8'(int'(ly) + int'($urandom_range(spread, 0)));
        oam[4*k+1] = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom);
        oam[4*k+2] = 8'($urandom);
        oam[4*k+3] = 8'($urandom);
      end
      scan(ly, 1'($urandom), $sformatf("rand%0d", r));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
